// File: rtl/alu_spi_master_pkg.sv
// rtl/alu_spi_master_pkg.sv - ISA types shared by the processor and the SPI ALU
package Isa;

    localparam int REGISTER_SIZE = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_AND = 2'd1,
        OP_OR  = 2'd2,
        OP_XOR = 2'd3
    } Instruction;

    // op_code sits in the LSBs so it is the first thing shifted out on the wire
    typedef struct packed {
        logic [REGISTER_SIZE-1:0] op_2;
        logic [REGISTER_SIZE-1:0] op_1;
        Instruction               op_code;
    } AluPacket;

endpackage

// File: rtl/alu_spi_master_if.sv
// rtl/alu_spi_master_if.sv - SPI bus between the ALU master and its slaves
interface Spi #(
    parameter int NUM_SLAVES = 2
);
    logic [NUM_SLAVES-1:0] nss;
    logic                  mosi;
    logic [0:0]            miso;

    modport MasterSpi (output nss, output mosi, input miso);
    modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

// File: rtl/alu_spi_master_piso_shift.sv
// rtl/alu_spi_master_piso_shift.sv - parallel-in serial-out shifter, LSB first
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_serial
);
    logic [WIDTH-1:0] shift_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift_q <= '0;
        end else if (i_load) begin
            shift_q <= i_data;
        end else if (i_shift) begin
            shift_q <= {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    assign o_serial = shift_q[0];
endmodule

// File: rtl/alu_spi_master.sv
// rtl/alu_spi_master.sv - serialises one ALU request over SPI and collects the result
module alu_spi_master
    import Isa::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  Instruction               i_op_code,
    input  logic [REGISTER_SIZE-1:0] i_op_1,
    input  logic [REGISTER_SIZE-1:0] i_op_2,
    output logic [REGISTER_SIZE-1:0] o_result,
    output logic                     o_done,
    output logic                     o_error,
    Spi.MasterSpi                    spi
);
    localparam int N  = $bits(AluPacket);
    localparam int CW = $clog2((N > REGISTER_SIZE) ? N : REGISTER_SIZE);
    localparam int RW = (REGISTER_SIZE > 1) ? $clog2(REGISTER_SIZE) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TRANSMIT,
        WAIT_RESULT,
        RECEIVING,
        DONE,
        ERROR
    } state_t;

    state_t                   state, state_next;
    logic [CW-1:0]            bit_cnt;
    logic [TW-1:0]            timeout_cnt;
    logic [REGISTER_SIZE-1:0] rx_data, rx_next;
    AluPacket                 packet_in;
    logic                     accept, tx_bit, tx_last, rx_last, timeout_last;

    assign accept       = (state == IDLE) && i_valid;
    assign tx_last      = (bit_cnt == CW'(N - 1));
    assign rx_last      = (bit_cnt == CW'(REGISTER_SIZE - 1));
    assign timeout_last = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign packet_in    = '{op_2: i_op_2, op_1: i_op_1, op_code: i_op_code};

    // The shifter holds the latched packet, so later operand changes cannot leak in
    piso_shift #(.WIDTH(N)) u_piso (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_load   (accept),
        .i_shift  (state == TRANSMIT),
        .i_data   (packet_in),
        .o_serial (tx_bit)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (i_valid) state_next = START;
            START:       state_next = TRANSMIT;
            TRANSMIT:    if (tx_last) state_next = WAIT_RESULT;
            WAIT_RESULT: begin
                if (spi.miso[0]) begin
                    state_next = RECEIVING;
                end else if (timeout_last) begin
                    state_next = ERROR;
                end
            end
            RECEIVING:   if (rx_last) state_next = DONE;
            DONE:        state_next = IDLE;
            ERROR:       state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_next                 = rx_data;
        rx_next[bit_cnt[RW-1:0]] = spi.miso[0];
    end

    // The received word is published on the edge into DONE so it is valid with o_done
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bit_cnt     <= '0;
            timeout_cnt <= '0;
            rx_data     <= '0;
            o_result    <= '0;
        end else begin
            case (state)
                TRANSMIT: bit_cnt <= tx_last ? '0 : bit_cnt + 1'b1;
                WAIT_RESULT: begin
                    if (spi.miso[0] || timeout_last) begin
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                RECEIVING: begin
                    rx_data <= rx_next;
                    bit_cnt <= rx_last ? '0 : bit_cnt + 1'b1;
                    if (rx_last) begin
                        o_result <= rx_next;
                    end
                end
                default: begin
                    bit_cnt     <= '0;
                    timeout_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        spi.nss  = '1;
        spi.mosi = 1'b0;
        o_ready  = 1'b0;
        o_done   = 1'b0;
        o_error  = 1'b0;
        case (state)
            IDLE:        o_ready = 1'b1;
            START: begin
                spi.nss[0] = 1'b0;
                spi.mosi   = 1'b1;
            end
            TRANSMIT: begin
                spi.nss[0] = 1'b0;
                spi.mosi   = tx_bit;
            end
            WAIT_RESULT: spi.nss[0] = 1'b0;
            RECEIVING:   spi.nss[0] = 1'b0;
            DONE:        o_done  = 1'b1;
            ERROR:       o_error = 1'b1;
            default:     ;
        endcase
    end
endmodule

// File: tb/tb_alu_spi_master.sv
// tb/tb_alu_spi_master.sv - directed bench for alu_spi_master with an SPI ALU slave model
module tb_alu_spi_master;
    import Isa::*;

    localparam int T       = 32;
    localparam int N       = $bits(AluPacket);
    localparam int R       = REGISTER_SIZE;
    localparam int NOMINAL = 1 + N + 2 + R;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    Instruction   op_code;
    logic [R-1:0] op_1, op_2;
    logic         o_ready, o_done, o_error;
    logic [R-1:0] o_result;

    int n_checks = 0;
    int n_pass   = 0;
    bit mute     = 1'b0;

    Spi spi_bus ();

    alu_spi_master #(.TIMEOUT_CYCLES(T)) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op_code (op_code),
        .i_op_1    (op_1),
        .i_op_2    (op_2),
        .o_result  (o_result),
        .o_done    (o_done),
        .o_error   (o_error),
        .spi       (spi_bus)
    );

    always #5 clk = ~clk;

    // ALU slave: start bit, N packet bits, one turnaround cycle, then start bit and result
    int           s_state = 0;
    int           s_cnt   = 0;
    logic [N-1:0] s_pkt;
    logic [R-1:0] s_res;

    function automatic logic [R-1:0] alu_model(input logic [N-1:0] p);
        AluPacket pk;
        pk = p;
        case (pk.op_code)
            OP_ADD:  return pk.op_1 + pk.op_2;
            OP_AND:  return pk.op_1 & pk.op_2;
            OP_OR:   return pk.op_1 | pk.op_2;
            default: return pk.op_1 ^ pk.op_2;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst || spi_bus.nss[0]) begin
            s_state = 0;
            spi_bus.miso = '0;
        end else begin
            case (s_state)
                0: if (spi_bus.mosi) begin s_state = 1; s_cnt = 0; end
                1: begin
                    s_pkt[s_cnt] = spi_bus.mosi;
                    if (s_cnt == N - 1) s_state = 2;
                    else s_cnt++;
                end
                2: begin
                    s_res = alu_model(s_pkt);
                    spi_bus.miso[0] = !mute;
                    s_state = 3;
                    s_cnt = 0;
                end
                3: begin
                    spi_bus.miso[0] = mute ? 1'b0 : s_res[s_cnt];
                    if (s_cnt == R - 1) s_state = 4;
                    else s_cnt++;
                end
                default: spi_bus.miso = '0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic start_op(input string tag, input Instruction op, input logic [R-1:0] a, input logic [R-1:0] b);
        i_valid = 1'b1;
        op_code = op;
        op_1    = a;
        op_2    = b;
        check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic finish_op(input string tag, input Instruction op, input logic [R-1:0] a,
                             input logic [R-1:0] b, input logic [R-1:0] exp, input bit hold,
                             input Instruction nop, input logic [R-1:0] na, input logic [R-1:0] nb);
        logic [N-1:0] cap;
        logic [1:0]   nss_start, nss_done;
        logic         mosi_start;
        int           k_done;
        cap        = '0;
        nss_start  = 2'b00;
        nss_done   = 2'b00;
        mosi_start = 1'b0;
        k_done     = 0;
        if (!hold) i_valid = 1'b0;
        op_code = Instruction'(~op);
        op_1    = ~a;
        op_2    = ~b;
        for (int k = 1; k <= NOMINAL + 10; k++) begin
            if (k == 1) begin
                nss_start  = spi_bus.nss;
                mosi_start = spi_bus.mosi;
            end
            if (k >= 2 && k <= N + 1) cap[k-2] = spi_bus.mosi;
            if (k == 15) begin
                op_code = nop;
                op_1    = na;
                op_2    = nb;
            end
            if (o_done || o_error) begin
                k_done   = k;
                nss_done = spi_bus.nss;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_start_nss"}, {30'd0, nss_start}, 32'h2);
        check({tag, "_start_mosi"}, {31'd0, mosi_start}, 32'd1);
        check({tag, "_packet"}, {14'd0, cap}, {14'd0, b, a, 2'(op)});
        check({tag, "_latency"}, k_done, NOMINAL);
        check({tag, "_no_error"}, {31'd0, o_error}, 32'd0);
        check({tag, "_result"}, {24'd0, o_result}, {24'd0, exp});
        check({tag, "_done_nss"}, {30'd0, nss_done}, 32'h3);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        int k_err;
        int n_done;
        spi_bus.miso = '0;
        rst     = 1'b1;
        i_valid = 1'b0;
        op_code = OP_ADD;
        op_1    = '0;
        op_2    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_nss", {30'd0, spi_bus.nss}, 32'h3);
        check("rst_mosi", {31'd0, spi_bus.mosi}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_error", {31'd0, o_error}, 32'd0);
        check("rst_result", {24'd0, o_result}, 32'd0);
        rst = 1'b0;

        start_op("add_0f", OP_ADD, 8'h0F, 8'h01);
        finish_op("add_0f", OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b0, OP_ADD, 8'h00, 8'h00);
        start_op("add_wrap", OP_ADD, 8'hFF, 8'h01);
        finish_op("add_wrap", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, OP_ADD, 8'h00, 8'h00);
        start_op("and", OP_AND, 8'hF0, 8'h3C);
        finish_op("and", OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, OP_ADD, 8'h00, 8'h00);
        start_op("or", OP_OR, 8'hF0, 8'h0C);
        finish_op("or", OP_OR, 8'hF0, 8'h0C, 8'hFC, 1'b0, OP_ADD, 8'h00, 8'h00);

        mute = 1'b1;
        start_op("timeout", OP_XOR, 8'h12, 8'h34);
        i_valid = 1'b0;
        k_err  = 0;
        n_done = 0;
        for (int k = 1; k <= 100; k++) begin
            if (o_done) n_done++;
            if (o_error) begin
                k_err = k;
                break;
            end
            @(posedge clk); #1;
        end
        check("timeout_cycle", k_err, N + 2 + T);
        check("timeout_result_held", {24'd0, o_result}, 32'hFC);
        check("timeout_nss", {30'd0, spi_bus.nss}, 32'h3);
        check("timeout_no_done", n_done, 0);
        @(posedge clk); #1;
        check("timeout_error_pulse", {31'd0, o_error}, 32'd0);
        check("timeout_idle_ready", {31'd0, o_ready}, 32'd1);
        mute = 1'b0;

        start_op("abort", OP_ADD, 8'hAA, 8'h55);
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_in_frame", {30'd0, spi_bus.nss}, 32'h2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_nss", {30'd0, spi_bus.nss}, 32'h3);
        check("abort_ready", {31'd0, o_ready}, 32'd1);
        check("abort_result", {24'd0, o_result}, 32'd0);
        start_op("after_abort", OP_ADD, 8'h02, 8'h03);
        finish_op("after_abort", OP_ADD, 8'h02, 8'h03, 8'h05, 1'b0, OP_ADD, 8'h00, 8'h00);

        start_op("b2b_0", OP_ADD, 8'h11, 8'h22);
        finish_op("b2b_0", OP_ADD, 8'h11, 8'h22, 8'h33, 1'b1, OP_AND, 8'h5A, 8'h0F);
        start_op("b2b_1", OP_AND, 8'h5A, 8'h0F);
        finish_op("b2b_1", OP_AND, 8'h5A, 8'h0F, 8'h0A, 1'b1, OP_XOR, 8'hC3, 8'h3C);
        start_op("b2b_2", OP_XOR, 8'hC3, 8'h3C);
        finish_op("b2b_2", OP_XOR, 8'hC3, 8'h3C, 8'hFF, 1'b0, OP_ADD, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_spi_master.md
ALU_SPI_MASTER -- requirements
Module: alu_spi_master

Interface
REQ-001 SHALL use parameter TIMEOUT_CYCLES, default 32, max cycles in WAIT_RESULT for the ALU start bit.
REQ-002 SHALL take REGISTER_SIZE, Instruction and AluPacket from package Isa; N = $bits(AluPacket).
REQ-003 i_clock  input  1  system clock; the only clock.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_valid  input  1  processor requests an ALU operation.
REQ-006 o_ready  output  1  high only in IDLE; the request is accepted on the edge where i_valid && o_ready.
REQ-007 i_op_code  input  $bits(Instruction)  operation; captured on accept.
REQ-008 i_op_1, i_op_2  input  REGISTER_SIZE each  operands; captured on accept.
REQ-009 o_result  output  REGISTER_SIZE  last received ALU result; holds until the next DONE.
REQ-010 o_done  output  1  one-cycle pulse; o_result is valid in that cycle.
REQ-011 o_error  output  1  one-cycle pulse in place of o_done on timeout.
REQ-012 spi  Spi.MasterSpi  drives nss, mosi and samples miso[0]; nss[0] addresses the ALU, and every other nss bit SHALL be held 1.

Function
REQ-013 States SHALL be IDLE, START, TRANSMIT, WAIT_RESULT, RECEIVING, DONE, ERROR.
REQ-014 On accept, SHALL latch packet = {op_2, op_1, op_code}, with op_code in the LSBs, and go to START.
REQ-015 IDLE: nss[0]=1, mosi=0.
REQ-016 START, exactly 1 cycle: nss[0]=0, mosi=1 (start bit).
REQ-017 TRANSMIT, exactly N cycles: nss[0]=0; cycle i drives mosi=packet[i], LSB first, from a bit counter 0..N-1; then go to WAIT_RESULT.
REQ-018 WAIT_RESULT: nss[0]=0, mosi=0.
  - miso[0]=1 sampled: go to RECEIVING; the timeout counter is cleared.
  - TIMEOUT_CYCLES cycles without miso[0]=1: go to ERROR.
REQ-019 RECEIVING, exactly REGISTER_SIZE cycles: nss[0]=0, mosi=0; cycle j samples miso[0] into shift register bit j, LSB first; then go to DONE.
REQ-020 DONE, 1 cycle: o_result updated with the assembled word, o_done=1, nss[0]=1; then go to IDLE.
REQ-021 ERROR, 1 cycle: o_error=1, nss[0]=1, o_result unchanged; then go to IDLE.
REQ-022 Nominal latency with a responsive ALU SHALL be 1 + N + 2 + REGISTER_SIZE cycles from accept edge to o_done cycle.
  - The 2 cycles are the ALU OPERATE and SEND states.
REQ-023 i_valid outside IDLE SHALL be ignored; no queuing.
REQ-024 Operand inputs changing after accept SHALL NOT affect the transaction in flight.
REQ-025 A single-cycle pulse of miso[0]=1 during RECEIVING SHALL be treated as a data bit, never as a start bit.
REQ-026 Back-to-back requests SHALL be possible: i_valid held high accepts a new request in the first IDLE cycle after DONE or ERROR.

Reset
REQ-027 With i_reset=1 at an edge, the block SHALL enter IDLE from any state, including mid-transaction.
  - nss all 1, mosi=0, o_done=0, o_error=0, o_result=0, counters=0, packet=0.
REQ-028 A reset mid-transaction SHALL raise nss[0] within one cycle, so the ALU sees the frame aborted.

Structure
REQ-029 State enum SHALL be local to the module; Instruction, AluPacket and REGISTER_SIZE SHALL come from Isa only.
REQ-030 A sub-module piso_shift (parallel-in serial-out, parameter WIDTH) MAY be used for TRANSMIT; everything else SHALL be inline.

Verification (REGISTER_SIZE=8, bench ALU slave model)
REQ-031 ADD 8'h0F, 8'h01 -> o_done exactly 1+N+2+8 cycles after accept, o_result=8'h10.
REQ-032 ADD 8'hFF, 8'h01 -> o_result=8'h00 (wrap-around); AND 8'hF0, 8'h3C -> 8'h30; OR 8'hF0, 8'h0C -> 8'hFC.
REQ-033 Slave never drives miso -> o_error pulse TIMEOUT_CYCLES cycles after TRANSMIT ends, o_result unchanged, nss[0]=1.
REQ-034 i_reset asserted in the 5th TRANSMIT cycle -> next cycle nss[0]=1, o_ready=1.
  - A following ADD 8'h02, 8'h03 -> 8'h05.
REQ-035 i_valid held high for 3 operations with operands toggled mid-transaction -> 3 o_done pulses with results of the latched operands, each at the nominal latency.
